// File: rtl/vxe_txnres_decoder_if.sv
// Bus bundle for the transaction response decoder: upstream coded vector
// handshake, downstream decoded fields handshake, and status/debug outputs.
interface vxe_txnres_decoder_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic [8:0]           i_res_vec_txn;
  logic                 i_res_vld;
  logic                 o_res_rdy;
  logic [5:0]           o_txnid;
  logic                 o_rnw;
  logic [1:0]           o_err;
  logic                 o_vld;
  logic                 i_rdy;
  logic [CNT_WIDTH-1:0] o_rd_cnt;
  logic [CNT_WIDTH-1:0] o_wr_cnt;
  logic                 i_err_clr;
  logic                 o_err_sticky;
  logic [8:0]           o_err_info;

  // Environment side: produces coded vectors, consumes decoded responses.
  modport master (
    output i_res_vec_txn, i_res_vld, i_rdy, i_err_clr,
    input  o_res_rdy, o_txnid, o_rnw, o_err, o_vld,
    input  o_rd_cnt, o_wr_cnt, o_err_sticky, o_err_info
  );

  // Decoder side.
  modport slave (
    input  i_res_vec_txn, i_res_vld, i_rdy, i_err_clr,
    output o_res_rdy, o_txnid, o_rnw, o_err, o_vld,
    output o_rd_cnt, o_wr_cnt, o_err_sticky, o_err_info
  );
endinterface

// File: rtl/vxe_txnres_decoder.sv
// Transaction response decoder: 2-entry skid buffer for coded response
// vectors {txnid[5:0], rnw, err[1:0]}, in-order decoded output, saturating
// read/write completion counters and a sticky first-error record.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. Valid never waits on ready; once the decoder
// raises o_vld it holds the fields stable until the consume edge. Upstream
// ready is a flop and is 0 whenever the buffer is full, so nothing is dropped.
module vxe_txnres_decoder #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  vxe_txnres_decoder_if.slave         bus,
  output logic [1:0]                  dbg_occ
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  occ_e                 occ_q;
  occ_e                 occ_d;
  logic                 res_rdy_q;
  logic [8:0]           head_q;
  logic [8:0]           tail_q;
  logic                 accept;
  logic                 consume;
  logic [CNT_WIDTH-1:0] rd_cnt_q;
  logic [CNT_WIDTH-1:0] wr_cnt_q;
  logic                 sticky_q;
  logic [8:0]           info_q;
  logic                 head_err;

  assign accept   = bus.i_res_vld && res_rdy_q;
  assign consume  = (occ_q != OCC_EMPTY) && bus.i_rdy;
  assign head_err = (head_q[1:0] != 2'b00);

  // Occupancy next-state from the accept/consume pair.
  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (accept) occ_d = OCC_ONE;
      end
      OCC_ONE: begin
        if (accept && !consume)      occ_d = OCC_TWO;
        else if (!accept && consume) occ_d = OCC_EMPTY;
      end
      OCC_TWO: begin
        if (consume) occ_d = OCC_ONE;
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // Occupancy register and registered upstream ready (low only when full).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q     <= OCC_EMPTY;
      res_rdy_q <= 1'b1;
    end else begin
      occ_q     <= occ_d;
      res_rdy_q <= (occ_d != OCC_TWO);
    end
  end

  // Entry storage: head is what is presented downstream, tail is the skid slot.
  // Accept in TWO cannot happen because ready is low there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) head_q <= bus.i_res_vec_txn;
        end
        OCC_ONE: begin
          if (accept && consume) head_q <= bus.i_res_vec_txn;
          else if (accept)       tail_q <= bus.i_res_vec_txn;
        end
        OCC_TWO: begin
          if (consume) head_q <= tail_q;
        end
        default: ;
      endcase
    end
  end

  // Completion counters, bumped on consume and held once saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (consume) begin
      if (head_q[2]) begin
        if (rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 1'b1;
      end else begin
        if (wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 1'b1;
      end
    end
  end

  // Sticky first-error record; a new error beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      info_q   <= '0;
    end else if (consume && head_err) begin
      sticky_q <= 1'b1;
      if (!sticky_q || bus.i_err_clr) info_q <= head_q;
    end else if (bus.i_err_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.o_res_rdy    = res_rdy_q;
  assign bus.o_vld        = (occ_q != OCC_EMPTY);
  assign bus.o_txnid      = head_q[8:3];
  assign bus.o_rnw        = head_q[2];
  assign bus.o_err        = head_q[1:0];
  assign bus.o_rd_cnt     = rd_cnt_q;
  assign bus.o_wr_cnt     = wr_cnt_q;
  assign bus.o_err_sticky = sticky_q;
  assign bus.o_err_info   = info_q;
  assign dbg_occ          = occ_q;

endmodule

// File: tb/tb_vxe_txnres_decoder.sv
// Bench for vxe_txnres_decoder: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a queue-based model.
`timescale 1ns/1ps
module tb_vxe_txnres_decoder;

  localparam int CW     = 3;
  localparam int CNTMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_occ;

  vxe_txnres_decoder_if #(.CNT_WIDTH(CW)) bus_if ();

  vxe_txnres_decoder #(.CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .dbg_occ (dbg_occ)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [8:0] exp_q[$];
  int         m_rd     = 0;
  int         m_wr     = 0;
  logic       m_sticky = 1'b0;
  logic [8:0] m_info   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] mk(input int txn, input int rnw, input int err);
    logic [5:0] t;
    logic       r;
    logic [1:0] e;
    t = txn[5:0];
    r = rnw[0];
    e = err[1:0];
    return {t, r, e};
  endfunction

  // model: FIFO of coded vectors plus counters and error record
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_rd     = 0;
      m_wr     = 0;
      m_sticky = 1'b0;
      m_info   = '0;
    end else begin
      logic       acc;
      logic       con;
      logic [8:0] h;
      acc = bus_if.i_res_vld && (exp_q.size() < 2);
      con = (exp_q.size() > 0) && bus_if.i_rdy;
      h   = '0;
      if (con) begin
        h = exp_q.pop_front();
        if (h[2]) m_rd = (m_rd < CNTMAX) ? m_rd + 1 : CNTMAX;
        else      m_wr = (m_wr < CNTMAX) ? m_wr + 1 : CNTMAX;
      end
      if (con && h[1:0] != 2'b00) begin
        if (!m_sticky || bus_if.i_err_clr) m_info = h;
        m_sticky = 1'b1;
      end else if (bus_if.i_err_clr) begin
        m_sticky = 1'b0;
      end
      if (acc) exp_q.push_back(bus_if.i_res_vec_txn);
    end
  end

  // compare process, mid-cycle
  always @(negedge clk) begin
    chk("o_vld", bus_if.o_vld, exp_q.size() != 0);
    chk("o_res_rdy", bus_if.o_res_rdy, exp_q.size() < 2);
    chk("occupancy", dbg_occ, exp_q.size());
    if (exp_q.size() != 0) begin
      chk("o_txnid", bus_if.o_txnid, exp_q[0][8:3]);
      chk("o_rnw", bus_if.o_rnw, exp_q[0][2]);
      chk("o_err", bus_if.o_err, exp_q[0][1:0]);
    end
    chk("o_rd_cnt", bus_if.o_rd_cnt, m_rd);
    chk("o_wr_cnt", bus_if.o_wr_cnt, m_wr);
    chk("o_err_sticky", bus_if.o_err_sticky, m_sticky);
    chk("o_err_info", bus_if.o_err_info, m_info);
  end

  // driver tasks: inputs change 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [8:0] vec, input logic rdy, input logic clr);
    bus_if.i_res_vld     = vld;
    bus_if.i_res_vec_txn = vec;
    bus_if.i_rdy         = rdy;
    bus_if.i_err_clr     = clr;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    chk("rst o_res_rdy", bus_if.o_res_rdy, 1);
    chk("rst o_vld", bus_if.o_vld, 0);
    chk("rst fields", {bus_if.o_txnid, bus_if.o_rnw, bus_if.o_err}, 0);
    chk("rst counters", {bus_if.o_rd_cnt, bus_if.o_wr_cnt}, 0);
    chk("rst sticky/info", {bus_if.o_err_sticky, bus_if.o_err_info}, 0);

    // single read, txnid 5
    drive(1'b1, 9'b000101_1_00, 1'b1, 1'b0);
    step();
    chk("single o_vld", bus_if.o_vld, 1);
    chk("single o_txnid", bus_if.o_txnid, 5);
    chk("single o_rnw", bus_if.o_rnw, 1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("single rd_cnt", bus_if.o_rd_cnt, 1);
    chk("single wr_cnt", bus_if.o_wr_cnt, 0);
    chk("single drained", bus_if.o_vld, 0);

    // backpressure: ids 1,2 accepted, 3 held upstream
    drive(1'b1, mk(1, 0, 0), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(2, 0, 0), 1'b0, 1'b0);
    step();
    chk("full rdy low", bus_if.o_res_rdy, 0);
    drive(1'b1, mk(3, 0, 0), 1'b0, 1'b0);
    step();
    chk("full head", bus_if.o_txnid, 1);
    drive(1'b1, mk(3, 0, 0), 1'b1, 1'b0);
    step();
    chk("release head", bus_if.o_txnid, 2);
    step();
    chk("release last", bus_if.o_txnid, 3);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("release wr_cnt", bus_if.o_wr_cnt, 3);

    // streaming, one per cycle
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, mk($urandom_range(0, 63), $urandom_range(0, 1), 0), 1'b1, 1'b0);
      step();
      chk("stream rdy", bus_if.o_res_rdy, 1);
      chk("stream occ", dbg_occ, 1);
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    step();

    // first error retained
    drive(1'b1, mk(7, 0, 2), 1'b1, 1'b0);
    step();
    drive(1'b1, mk(9, 1, 1), 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("err sticky", bus_if.o_err_sticky, 1);
    chk("err info", bus_if.o_err_info, 9'b000111_0_10);

    // clear and new error together: set wins, info recaptured
    drive(1'b1, mk(12, 1, 3), 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    chk("clr+err sticky", bus_if.o_err_sticky, 1);
    chk("clr+err info", bus_if.o_err_info, 9'b001100_1_11);
    step();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("lone clr", bus_if.o_err_sticky, 0);
    chk("lone clr info", bus_if.o_err_info, 9'b001100_1_11);

    // read counter saturation
    for (int i = 0; i < CNTMAX + 2; i++) begin
      drive(1'b1, mk(i, 1, 0), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("rd saturated", bus_if.o_rd_cnt, CNTMAX);

    // async reset with two entries buffered
    drive(1'b1, mk(20, 1, 0), 1'b0, 1'b0);
    step();
    drive(1'b1, mk(21, 0, 1), 1'b0, 1'b0);
    step();
    chk("pre-rst occ", dbg_occ, 2);
    #2 rst = 1'b1;
    #1;
    chk("async o_vld", bus_if.o_vld, 0);
    chk("async o_res_rdy", bus_if.o_res_rdy, 1);
    chk("async counters", {bus_if.o_rd_cnt, bus_if.o_wr_cnt}, 0);
    drive(1'b0, '0, 1'b0, 1'b0);
    step();
    rst = 1'b0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, 9'($urandom_range(0, 511)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
